matrix_stream_packer: RTL and testbench

Assembles a row-major stream of signed fixed-point elements into one flat H×W packed matrix bus, the input format `matrix_adder` consumes. It is the producer end of that interface. Elements arrive one per beat over a valid/ready handshake with an end-of-frame marker. A complete matrix is presented on `y` with `y_valid` and held until the consumer accepts it. Frame-length errors are flagged and the bad frame is discarded.

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/matrix_stream_packer.sv | 121 ++++++++++++
 tb/tb_matrix_stream_packer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared FSM states and packed-matrix helpers for matrix streaming.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Counter width for n slots; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bit offset of element (i,j) in a row-major packed matrix bus.
    function automatic int slot_offset(input int i, input int j,
                                       input int w, input int dw);
        return (i * w + j) * dw;
    endfunction

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/matrix_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_packer
// Brief    : Packs a row-major element stream into one flat HxW matrix bus.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_packer
    import matrix_pkg::*;
#(
    parameter int H           = 8,
    parameter int W           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    output logic [H*W*DATA_WIDTH-1:0]      y,
    output logic                           y_valid,
    input  logic                           y_ready,
    output logic                           err_len
);

    localparam int              c_SLOTS = H * W;
    localparam int              c_IDXW  = idx_width(c_SLOTS);
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_SLOTS - 1);

    // Element values are opaque here; only reject impossible formats.
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_fract_check
        $error("FRACT_WIDTH must be smaller than DATA_WIDTH");
    end

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_IDXW-1:0]             r_idx;
    logic [c_IDXW-1:0]             w_idx_nxt;
    logic [H*W*DATA_WIDTH-1:0]     r_mat;
    logic                          r_err;
    logic                          w_err_nxt;
    logic                          w_store;
    logic                          w_accept;

    assign in_ready = (r_state != HOLD);
    assign y_valid  = (r_state == HOLD);
    assign y        = r_mat;
    assign err_len  = r_err;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        w_store     = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (r_idx != c_LAST) begin
                        if (in_last) begin
                            w_err_nxt = 1'b1;
                            w_idx_nxt = '0;
                        end else begin
                            w_store   = 1'b1;
                            w_idx_nxt = r_idx + c_IDXW'(1);
                        end
                    end else begin
                        // Last slot is written even for an over-long frame.
                        w_store     = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = in_last ? HOLD : DRAIN;
                        w_err_nxt   = !in_last;
                    end
                end
            end
            HOLD: begin
                if (y_ready) begin
                    w_state_nxt = FILL;
                    w_idx_nxt   = '0;
                end
            end
            DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = FILL;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat <= '0;
        end else if (w_store) begin
            for (int k = 0; k < c_SLOTS; k++) begin
                if (r_idx == c_IDXW'(k)) begin
                    r_mat[slot_offset(k / W, k % W, W, DATA_WIDTH) +: DATA_WIDTH] <= in_data;
                end
            end
        end
    end

endmodule : matrix_stream_packer
`default_nettype wire

// File: tb/tb_matrix_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_stream_packer
// Brief    : Directed self-checking bench for a 2x2, 16-bit packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_stream_packer;

    localparam int c_H  = 2;
    localparam int c_W  = 2;
    localparam int c_DW = 16;

    logic                    clk;
    logic                    rst_n;
    logic [c_DW-1:0]         in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [c_H*c_W*c_DW-1:0] y;
    logic                    y_valid;
    logic                    y_ready;
    logic                    err_len;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_stream_packer #(
        .H           (c_H),
        .W           (c_W),
        .DATA_WIDTH  (c_DW),
        .FRACT_WIDTH (8)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .err_len  (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One beat offered for one clock; sampling happens 1 time unit after the edge.
    task automatic send(input logic [c_DW-1:0] d, input logic last);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] held_y;

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        y_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();

        check("rst_y",        y,        64'h0);
        check("rst_y_valid",  y_valid,  64'h0);
        check("rst_err_len",  err_len,  64'h0);
        check("rst_in_ready", in_ready, 64'h1);

        // Nominal frame
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        check("nom_pre_valid", y_valid, 64'h0);
        send(16'hFFF0, 1'b1);
        check("nom_y",        y,        64'hFFF0_0003_0002_0001);
        check("nom_y_valid",  y_valid,  64'h1);
        check("nom_in_ready", in_ready, 64'h0);
        check("nom_err_len",  err_len,  64'h0);

        // Backpressure while a new element is being offered
        held_y   = y;
        in_data  = 16'h5555;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            idle_cycle();
            check("bp_y_stable", y,        held_y);
            check("bp_in_ready", in_ready, 64'h0);
            check("bp_y_valid",  y_valid,  64'h1);
        end
        in_valid = 1'b0;
        y_ready  = 1'b1;
        idle_cycle();
        y_ready  = 1'b0;
        check("xfer_y_valid",  y_valid,  64'h0);
        check("xfer_in_ready", in_ready, 64'h1);

        // Short frame, then a good frame
        send(16'h0011, 1'b0);
        check("short_no_err", err_len, 64'h0);
        send(16'h0022, 1'b1);
        check("short_err",    err_len, 64'h1);
        check("short_no_val", y_valid, 64'h0);
        idle_cycle();
        check("short_err_one", err_len, 64'h0);
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b1);
        check("after_short_y",     y,       64'h0008_0007_0006_0005);
        check("after_short_valid", y_valid, 64'h1);
        check("after_short_err",   err_len, 64'h0);
        y_ready = 1'b1;
        idle_cycle();
        y_ready = 1'b0;
        check("after_short_xfer", y_valid, 64'h0);

        // Long frame: error after element 4, then drain until in_last
        send(16'h0101, 1'b0);
        send(16'h0102, 1'b0);
        send(16'h0103, 1'b0);
        send(16'h0104, 1'b0);
        check("long_err",      err_len,  64'h1);
        check("long_no_valid", y_valid,  64'h0);
        check("long_ready4",   in_ready, 64'h1);
        send(16'h0105, 1'b0);
        check("long_err_once", err_len,  64'h0);
        check("long_ready5",   in_ready, 64'h1);
        send(16'h0106, 1'b1);
        check("long_err_end",  err_len,  64'h0);
        check("long_ready6",   in_ready, 64'h1);
        check("long_valid6",   y_valid,  64'h0);
        idle_cycle();
        check("long_valid_idle", y_valid, 64'h0);

        // Reset mid-fill: asynchronous clear, then a clean frame
        send(16'h0077, 1'b0);
        send(16'h0088, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_y",       y,        64'h0);
        check("mid_rst_ready",   in_ready, 64'h1);
        check("mid_rst_y_valid", y_valid,  64'h0);
        idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        send(16'h0009, 1'b0);
        send(16'h000A, 1'b0);
        send(16'h000B, 1'b0);
        check("rst_frame_no_err", err_len, 64'h0);
        send(16'h000C, 1'b1);
        check("rst_frame_y",     y,       64'h000C_000B_000A_0009);
        check("rst_frame_valid", y_valid, 64'h1);
        check("rst_frame_err",   err_len, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_matrix_stream_packer
`default_nettype wire
